hangman_word_engine: RTL
========================

Name: hangman_word_engine

Overview:
Parametrised word-entry and guess-evaluation engine for the Hangman game. It sits between the keyboard ASCII decoder and the VGA letter/gallows renderer. It loads a secret word of up to MAX_LEN letters, then evaluates guesses against the stored word and tracks the reveal mask, used letters, misses and win/lose. Every visible change is handed to the renderer through a req/ack draw handshake.

Parameters:
MAX_LEN, 10, maximum word length in letters (2..16)
IDX_W, 4, width of letter index and length fields; must satisfy 2^IDX_W > MAX_LEN
MAX_MISSES, 6, number of misses that ends the game in LOSE (1..7)
ENTER_CODE, 8'h0D, ASCII code that terminates word entry

Ports:
clock  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a new word load
key_valid  in  1  key_code is valid this cycle
key_code  in  8  ASCII key code
key_ready  out  1  engine will accept a key this cycle
draw_req  out  1  draw request to the renderer
draw_kind  out  2  0 = blank slot, 1 = revealed letter, 2 = gallows part, 3 = clear screen
draw_idx  out  IDX_W  slot index, or gallows part number (1..MAX_MISSES)
draw_char  out  8  uppercase ASCII character to draw
draw_ack  in  1  renderer finished the current request
word_len  out  IDX_W  number of letters loaded
reveal_mask  out  MAX_LEN  bit i set = slot i revealed
miss_count  out  3  misses so far
win  out  1  level; all slots revealed
lose  out  1  level; miss_count reached MAX_MISSES

Behaviour:
- Reset (async, resetn low): state IDLE. Every output is 0, and the word buffer and the 26-bit used-letter mask are cleared. A draw_req in flight is dropped immediately.
- Letter = 0x41..0x5A or 0x61..0x7A. Lowercase is folded to uppercase (clear bit 5) before storing or comparing. Any other code is not a letter.
- A key is accepted only when key_valid && key_ready. key_ready = 1 only in LOAD or GUESS with no draw pending. Keys at any other time are dropped; there is no buffering.
- States: IDLE, CLR, LOAD, LDRAW, GUESS, CHECK, RDRAW, MDRAW, WIN, LOSE.
- IDLE / WIN / LOSE: a start pulse clears word_len, reveal_mask, miss_count, win, lose and the used-letter mask, then goes to CLR. start is ignored in every other state.
- CLR: issues one request with draw_kind=3. After draw_ack it goes to LOAD.
- LOAD, letter key with word_len < MAX_LEN: store the letter at slot word_len, then go to LDRAW. LDRAW requests kind=0, idx=old word_len. After draw_ack, word_len increments and the engine returns to LOAD.
- LOAD, letter key with word_len == MAX_LEN: ignored.
- LOAD, ENTER_CODE: with word_len >= 1, go to GUESS; with word_len == 0, ignored.
- LOAD, other non-letter keys: ignored.
- GUESS, letter key: latch it and go to CHECK. Non-letter keys are ignored.
- CHECK (exactly 1 cycle): compare the letter against all word_len slots in parallel.
  - Letter already in the used mask: no change, return to GUESS.
  - Otherwise set its used bit.
  - Hit: OR the match vector into a pending set, go to RDRAW.
  - Miss: increment miss_count, go to MDRAW.
- RDRAW: walks the pending set from the lowest index up. For each slot it requests kind=1 with idx and char, sets that reveal_mask bit on ack, then moves to the next slot. When the pending set is empty it goes to WIN if all word_len bits are set, else to GUESS.
- MDRAW: requests kind=2, idx=miss_count (the new value). After ack it goes to LOSE if miss_count == MAX_MISSES, else to GUESS.
- Handshake rules:
  - draw_req rises the cycle after entering a draw state.
  - draw_kind, draw_idx and draw_char are held stable while draw_req = 1.
  - The request completes on the cycle draw_ack is sampled high. draw_req drops the next cycle.
  - The next request can rise no earlier than the cycle after that.
  - draw_ack while draw_req = 0 is ignored.
- Latency: a key accepted in GUESS at cycle t → CHECK at t+1 → first draw_req at t+3.
- WIN / LOSE are held until start or reset. reveal_mask stays frozen.

Optional Feature:
HANGMAN_BACKSPACE_EN.
- Defined: in LOAD, key 0x08 with word_len > 0 decrements word_len and requests kind=3 for that slot (erase, idx = new word_len). With word_len == 0 the key is ignored.
- Not defined: 0x08 is treated like any other non-letter and ignored. The MDRAW/RDRAW logic is unaffected.

Test Plan:
- Reset, then start. Expect a kind=3 request. Ack after 2 cycles. Load "cat" (0x63 0x61 0x74), then Enter. Expect three kind=0 requests with idx 0,1,2, word_len=3, and the GUESS state.
- Word "CAT", guess 'A'. Expect CHECK, then a kind=1 request with idx=1 and char=0x41; reveal_mask=3'b010 after ack. Guess 'A' again: no request and miss_count stays 0.
- Word "BOOK", guess 'O'. Expect two kind=1 requests, idx 1 then idx 2. Then guess 'B' and 'K'. win=1 after the last ack, and keys are ignored after that.
- MAX_MISSES=6, word "X", guess Q,W,E,R,T,Y. Expect kind=2 requests with idx 1..6. lose=1 after the 6th ack, and miss_count=6.
- Load 10 letters, then send an 11th letter. Expect no request and word_len=10. Hold draw_ack low for 50 cycles during a draw: draw_req stays high and key_ready stays 0.
- Assert resetn low mid-RDRAW. Outputs go to 0 immediately. With HANGMAN_BACKSPACE_EN, the sequence "AB", 0x08 gives word_len=1 and a kind=3 request with idx=1.

Source files
------------

// File: rtl/hangman_word_engine.sv
// Hangman word-entry and guess-evaluation engine with a req/ack draw port to the renderer.
// Optional feature macro: HANGMAN_BACKSPACE_EN (0x08 in LOAD erases the last loaded letter).
module hangman_word_engine #(
    parameter int unsigned MAX_LEN    = 10,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned MAX_MISSES = 6,
    parameter logic [7:0]  ENTER_CODE = 8'h0D
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               key_valid,
    input  logic [7:0]         key_code,
    output logic               key_ready,
    output logic               draw_req,
    output logic [1:0]         draw_kind,
    output logic [IDX_W-1:0]   draw_idx,
    output logic [7:0]         draw_char,
    input  logic               draw_ack,
    output logic [IDX_W-1:0]   word_len,
    output logic [MAX_LEN-1:0] reveal_mask,
    output logic [2:0]         miss_count,
    output logic               win,
    output logic               lose
);
    localparam int unsigned ALPHA = 26;
    localparam logic [1:0] KIND_BLANK   = 2'd0;
    localparam logic [1:0] KIND_REVEAL  = 2'd1;
    localparam logic [1:0] KIND_GALLOWS = 2'd2;
    localparam logic [1:0] KIND_CLEAR   = 2'd3;
`ifdef HANGMAN_BACKSPACE_EN
    localparam logic [7:0] BS_CODE = 8'h08;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_LOAD, S_LDRAW, S_GUESS,
        S_CHECK, S_RDRAW, S_MDRAW, S_WIN, S_LOSE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         word_q [MAX_LEN];
    logic [7:0]         word_d [MAX_LEN];
    logic [IDX_W-1:0]   word_len_q, word_len_d;
    logic [MAX_LEN-1:0] reveal_q, reveal_d;
    logic [MAX_LEN-1:0] pending_q, pending_d;
    logic [ALPHA-1:0]   used_q, used_d;
    logic [2:0]         miss_q, miss_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic [7:0]         guess_q, guess_d;
    logic               erase_q, erase_d;
    logic               key_ready_q, key_ready_d;
    logic               draw_req_q, draw_req_d;
    logic [1:0]         draw_kind_q, draw_kind_d;
    logic [IDX_W-1:0]   draw_idx_q, draw_idx_d;
    logic [7:0]         draw_char_q, draw_char_d;

    logic               key_fire;
    logic               key_is_letter;
    logic [7:0]         key_upper;
    logic               len_full;
    logic [ALPHA-1:0]   guess_oh;
    logic               used_hit;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] match_vec;
    logic [MAX_LEN-1:0] first_oh;
    logic [IDX_W-1:0]   first_idx;
    logic [7:0]         first_char;

    // Key decode, parallel compare and lowest-pending-slot pick
    always_comb begin
        key_fire      = key_valid && key_ready_q;
        key_upper     = key_code & 8'hDF;
        key_is_letter = ((key_code >= 8'h41) && (key_code <= 8'h5A)) ||
                        ((key_code >= 8'h61) && (key_code <= 8'h7A));
        len_full      = (word_len_q == IDX_W'(MAX_LEN));
        guess_oh      = ALPHA'(1) << 5'(guess_q - 8'h41);
        used_hit      = |(used_q & guess_oh);
        len_mask      = '0;
        match_vec     = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i]  = (IDX_W'(i) < word_len_q);
            match_vec[i] = len_mask[i] && (word_q[i] == guess_q);
        end
        first_idx  = '0;
        first_char = '0;
        first_oh   = '0;
        for (int i = int'(MAX_LEN) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_idx   = IDX_W'(i);
                first_char  = word_q[i];
                first_oh    = '0;
                first_oh[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            word_d[i] = word_q[i];
        end
        word_len_d  = word_len_q;
        reveal_d    = reveal_q;
        pending_d   = pending_q;
        used_d      = used_q;
        miss_d      = miss_q;
        win_d       = win_q;
        lose_d      = lose_q;
        guess_d     = guess_q;
        erase_d     = erase_q;
        draw_req_d  = draw_req_q;
        draw_kind_d = draw_kind_q;
        draw_idx_d  = draw_idx_q;
        draw_char_d = draw_char_q;

        unique case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    word_len_d = '0;
                    reveal_d   = '0;
                    pending_d  = '0;
                    used_d     = '0;
                    miss_d     = '0;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                    state_d    = S_CLR;
                end
            end
            S_CLR: begin
                if (!draw_req_q) begin
                    draw_req_d  = 1'b1;
                    draw_kind_d = KIND_CLEAR;
                    draw_idx_d  = '0;
                    draw_char_d = '0;
                end else if (draw_ack) begin
                    draw_req_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (key_fire) begin
                    if (key_is_letter) begin
                        if (!len_full) begin
                            for (int i = 0; i < int'(MAX_LEN); i++) begin
                                if (IDX_W'(i) == word_len_q) word_d[i] = key_upper;
                            end
                            erase_d = 1'b0;
                            state_d = S_LDRAW;
                        end
                    end else if (key_code == ENTER_CODE) begin
                        if (word_len_q != '0) state_d = S_GUESS;
                    end
`ifdef HANGMAN_BACKSPACE_EN
                    else if ((key_code == BS_CODE) && (word_len_q != '0)) begin
                        word_len_d = word_len_q - IDX_W'(1);
                        erase_d    = 1'b1;
                        state_d    = S_LDRAW;
                    end
`endif
                end
            end
            S_LDRAW: begin
                // word_len already points at the slot for both a new letter and an erase
                if (!draw_req_q) begin
                    draw_req_d  = 1'b1;
                    draw_kind_d = erase_q ? KIND_CLEAR : KIND_BLANK;
                    draw_idx_d  = word_len_q;
                    draw_char_d = '0;
                end else if (draw_ack) begin
                    draw_req_d = 1'b0;
                    if (!erase_q) word_len_d = word_len_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_GUESS: begin
                if (key_fire && key_is_letter) begin
                    guess_d = key_upper;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (used_hit) begin
                    state_d = S_GUESS;
                end else begin
                    used_d = used_q | guess_oh;
                    if (|match_vec) begin
                        pending_d = pending_q | match_vec;
                        state_d   = S_RDRAW;
                    end else begin
                        miss_d  = miss_q + 3'd1;
                        state_d = S_MDRAW;
                    end
                end
            end
            S_RDRAW: begin
                if (!draw_req_q) begin
                    draw_req_d  = 1'b1;
                    draw_kind_d = KIND_REVEAL;
                    draw_idx_d  = first_idx;
                    draw_char_d = first_char;
                end else if (draw_ack) begin
                    draw_req_d = 1'b0;
                    reveal_d   = reveal_q | first_oh;
                    pending_d  = pending_q & ~first_oh;
                    if (pending_d == '0) begin
                        if ((reveal_d & len_mask) == len_mask) begin
                            win_d   = 1'b1;
                            state_d = S_WIN;
                        end else begin
                            state_d = S_GUESS;
                        end
                    end
                end
            end
            S_MDRAW: begin
                if (!draw_req_q) begin
                    draw_req_d  = 1'b1;
                    draw_kind_d = KIND_GALLOWS;
                    draw_idx_d  = IDX_W'(miss_q);
                    draw_char_d = '0;
                end else if (draw_ack) begin
                    draw_req_d = 1'b0;
                    if (miss_q == 3'(MAX_MISSES)) begin
                        lose_d  = 1'b1;
                        state_d = S_LOSE;
                    end else begin
                        state_d = S_GUESS;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        key_ready_d = (state_d == S_LOAD) || (state_d == S_GUESS);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                word_q[i] <= '0;
            end
            word_len_q  <= '0;
            reveal_q    <= '0;
            pending_q   <= '0;
            used_q      <= '0;
            miss_q      <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            guess_q     <= '0;
            erase_q     <= 1'b0;
            key_ready_q <= 1'b0;
            draw_req_q  <= 1'b0;
            draw_kind_q <= '0;
            draw_idx_q  <= '0;
            draw_char_q <= '0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                word_q[i] <= word_d[i];
            end
            word_len_q  <= word_len_d;
            reveal_q    <= reveal_d;
            pending_q   <= pending_d;
            used_q      <= used_d;
            miss_q      <= miss_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            guess_q     <= guess_d;
            erase_q     <= erase_d;
            key_ready_q <= key_ready_d;
            draw_req_q  <= draw_req_d;
            draw_kind_q <= draw_kind_d;
            draw_idx_q  <= draw_idx_d;
            draw_char_q <= draw_char_d;
        end
    end

    assign key_ready   = key_ready_q;
    assign draw_req    = draw_req_q;
    assign draw_kind   = draw_kind_q;
    assign draw_idx    = draw_idx_q;
    assign draw_char   = draw_char_q;
    assign word_len    = word_len_q;
    assign reveal_mask = reveal_q;
    assign miss_count  = miss_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule
